// File: rtl/tmu_pkg.sv
// Shared types and width helpers for the TMU write-combining burst assembler.
package tmu_pkg;

  typedef enum logic {
    RUNNING    = 1'b0,
    DOWNSTREAM = 1'b1
  } wc_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Pixels per burst, lane-offset width and burst-address width.
  function automatic int unsigned wc_ppb(input int unsigned pixel_width, input int unsigned burst_width);
    return burst_width / pixel_width;
  endfunction

  function automatic int unsigned wc_ow(input int unsigned pixel_width, input int unsigned burst_width);
    return clog2(burst_width / pixel_width);
  endfunction

  function automatic int unsigned wc_bw(input int unsigned fml_depth, input int unsigned burst_width);
    return fml_depth - clog2(burst_width / 8);
  endfunction

endpackage

// File: rtl/tmu_burst_wc_line.sv
// One combining line: tag, per-pixel select and data, with lane decode.
module tmu_burst_line
  import tmu_pkg::*;
#(
  parameter int unsigned pixel_width = 16,
  parameter int unsigned ppb         = 16,
  parameter int unsigned ow          = 4,
  parameter int unsigned tag_width   = 21
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       wr,
  input  logic                       alloc,
  input  logic                       clr,
  input  logic [tag_width-1:0]       tag_in,
  input  logic [ow-1:0]              off,
  input  logic [pixel_width-1:0]     pix,
  output logic [tag_width-1:0]       tag,
  output logic [ppb-1:0]             sel,
  output logic [ppb*pixel_width-1:0] data
);

  logic [ow-1:0]  lane;
  logic [ppb-1:0] lane_oh;

  // Offset 0 is the MSB lane, so the lane index is ppb-1-off == ~off.
  always_comb begin
    lane    = ~off;
    lane_oh = ppb'(1) << lane;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag  <= '0;
      sel  <= '0;
      data <= '0;
    end else begin
      if (clr) begin
        sel <= '0;
      end else if (alloc) begin
        tag <= tag_in;
        sel <= lane_oh;
      end else if (wr) begin
        sel <= sel | lane_oh;
      end
      if (alloc || wr) begin
        for (int k = 0; k < int'(ppb); k++) begin
          if (lane_oh[k]) data[k*pixel_width +: pixel_width] <= pix;
        end
      end
    end
  end

endmodule

// File: rtl/tmu_burst_wc.sv
// Multi-line write-combining burst assembler with oldest-first eviction.
module tmu_burst_wc
  import tmu_pkg::*;
#(
  parameter  int unsigned fml_depth   = 26,
  parameter  int unsigned pixel_width = 16,
  parameter  int unsigned burst_width = 256,
  parameter  int unsigned nlines      = 2,
  parameter  int unsigned timeout     = 0,
  localparam int unsigned ppb         = wc_ppb(pixel_width, burst_width),
  localparam int unsigned ow          = wc_ow(pixel_width, burst_width),
  localparam int unsigned aw          = fml_depth - clog2(pixel_width / 8),
  localparam int unsigned bw          = wc_bw(fml_depth, burst_width)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   flush,
  output logic                   busy,
  input  logic                   pipe_stb_i,
  output logic                   pipe_ack_o,
  input  logic [pixel_width-1:0] src_pixel_d,
  input  logic [aw-1:0]          dst_addr,
  output logic                   pipe_stb_o,
  input  logic                   pipe_ack_i,
  output logic [bw-1:0]          burst_addr,
  output logic [ppb-1:0]         burst_sel,
  output logic [burst_width-1:0] burst_do
);

  localparam int unsigned xw = (nlines > 1) ? clog2(nlines) : 1;
  localparam int unsigned rw = clog2(nlines) + 1;

  wc_state_e state_q, state_d;

  logic [bw-1:0]          tag_in;
  logic [ow-1:0]          off;
  logic [bw-1:0]          line_tag  [nlines];
  logic [ppb-1:0]         line_sel  [nlines];
  logic [burst_width-1:0] line_data [nlines];
  logic [rw-1:0]          rank_q    [nlines];
  logic [nlines-1:0]      line_wr, line_alloc, line_clr, line_empty;

  logic          hit, any_empty, all_empty, evict_now, accept, idle_hit, found;
  logic [xw-1:0] hit_idx, emp_idx, vic_idx, vidx_q;
  logic [rw-1:0] best;

  assign tag_in = dst_addr[aw-1:ow];
  assign off    = dst_addr[ow-1:0];

  for (genvar g = 0; g < int'(nlines); g++) begin : g_line
    tmu_burst_line #(
      .pixel_width(pixel_width),
      .ppb        (ppb),
      .ow         (ow),
      .tag_width  (bw)
    ) u_line (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .wr       (line_wr[g]),
      .alloc    (line_alloc[g]),
      .clr      (line_clr[g]),
      .tag_in   (tag_in),
      .off      (off),
      .pix      (src_pixel_d),
      .tag      (line_tag[g]),
      .sel      (line_sel[g]),
      .data     (line_data[g])
    );
    assign line_empty[g] = (line_sel[g] == '0);
  end

  assign all_empty = &line_empty;

  // Hit lookup, lowest free line, and victim (highest rank == oldest).
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    any_empty = 1'b0;
    emp_idx   = '0;
    vic_idx   = '0;
    best      = '0;
    found     = 1'b0;
    for (int i = 0; i < int'(nlines); i++) begin
      if (!line_empty[i] && line_tag[i] == tag_in) begin
        hit     = 1'b1;
        hit_idx = xw'(i);
      end
      if (!line_empty[i] && (!found || rank_q[i] > best)) begin
        found   = 1'b1;
        best    = rank_q[i];
        vic_idx = xw'(i);
      end
    end
    for (int i = int'(nlines) - 1; i >= 0; i--) begin
      if (line_empty[i]) begin
        any_empty = 1'b1;
        emp_idx   = xw'(i);
      end
    end
  end

  if (timeout != 0) begin : g_idle
    localparam int unsigned iw = clog2(timeout + 1);
    logic [iw-1:0] idle_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        idle_q <= '0;
      end else if (evict_now || accept || all_empty) begin
        idle_q <= '0;
      end else if (state_q == RUNNING && idle_q != iw'(timeout)) begin
        idle_q <= idle_q + iw'(1);
      end
    end

    assign idle_hit = (idle_q == iw'(timeout)) && !all_empty;
  end else begin : g_no_idle
    assign idle_hit = 1'b0;
  end

  always_comb begin
    evict_now  = (state_q == RUNNING) &&
                 ((pipe_stb_i && !hit && !any_empty) || (flush && !all_empty) || idle_hit);
    pipe_ack_o = (state_q == RUNNING) && !flush && !evict_now && (hit || any_empty);
    accept     = pipe_stb_i && pipe_ack_o;
    busy       = (state_q == DOWNSTREAM) || (flush && !all_empty);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= RUNNING;
    else            state_q <= state_d;
  end

  // Next state and per-line strobes.
  always_comb begin
    state_d    = state_q;
    line_wr    = '0;
    line_alloc = '0;
    line_clr   = '0;
    case (state_q)
      RUNNING: begin
        if (evict_now) state_d = DOWNSTREAM;
        for (int i = 0; i < int'(nlines); i++) begin
          line_wr[i]    = accept && hit && (hit_idx == xw'(i));
          line_alloc[i] = accept && !hit && (emp_idx == xw'(i));
        end
      end
      DOWNSTREAM: begin
        if (pipe_ack_i) state_d = RUNNING;
        for (int i = 0; i < int'(nlines); i++) begin
          line_clr[i] = pipe_ack_i && (vidx_q == xw'(i));
        end
      end
      default: state_d = RUNNING;
    endcase
  end

  // Age ranks: a newly allocated line is youngest, every other live line ages.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(nlines); i++) rank_q[i] <= '0;
    end else if (|line_alloc) begin
      for (int i = 0; i < int'(nlines); i++) begin
        if (line_alloc[i])      rank_q[i] <= '0;
        else if (!line_empty[i]) rank_q[i] <= rank_q[i] + rw'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_stb_o <= 1'b0;
      burst_addr <= '0;
      burst_sel  <= '0;
      burst_do   <= '0;
      vidx_q     <= '0;
    end else if (evict_now) begin
      pipe_stb_o <= 1'b1;
      burst_addr <= line_tag[vic_idx];
      burst_sel  <= line_sel[vic_idx];
      burst_do   <= line_data[vic_idx];
      vidx_q     <= vic_idx;
    end else if (state_q == DOWNSTREAM && pipe_ack_i) begin
      pipe_stb_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmu_burst_wc.sv
// Self-checking bench for tmu_burst_wc: vector table, corner sequences, random vs model.
module tb_tmu_burst_wc;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic         flush, pipe_stb_i, pipe_ack_i;
  logic [15:0]  src_pixel_d;
  logic [24:0]  dst_addr;
  logic         busy, pipe_ack_o, pipe_stb_o;
  logic [20:0]  burst_addr;
  logic [15:0]  burst_sel;
  logic [255:0] burst_do;
  logic         t_busy, t_ack, t_stb;
  logic [20:0]  t_addr;
  logic [15:0]  t_sel;
  logic [255:0] t_do;

  int n_vec = 0;
  int n_bad = 0;
  logic c_ack, c_busy, c_tack, c_tbusy;

  always #5 sys_clk = ~sys_clk;

  tmu_burst_wc dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush), .busy(busy),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o), .src_pixel_d(src_pixel_d),
    .dst_addr(dst_addr), .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
    .burst_addr(burst_addr), .burst_sel(burst_sel), .burst_do(burst_do)
  );

  tmu_burst_wc #(.timeout(8)) dut_to (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush), .busy(t_busy),
    .pipe_stb_i(pipe_stb_i), .pipe_ack_o(t_ack), .src_pixel_d(src_pixel_d),
    .dst_addr(dst_addr), .pipe_stb_o(t_stb), .pipe_ack_i(pipe_ack_i),
    .burst_addr(t_addr), .burst_sel(t_sel), .burst_do(t_do)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, samples combinational outputs at negedge.
  task automatic step(input logic stb, input logic [24:0] a, input logic [15:0] p,
                      input logic fl, input logic ak);
    pipe_stb_i = stb; dst_addr = a; src_pixel_d = p; flush = fl; pipe_ack_i = ak;
    @(negedge sys_clk);
    c_ack = pipe_ack_o; c_busy = busy; c_tack = t_ack; c_tbusy = t_busy;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    pipe_stb_i = 0; dst_addr = '0; src_pixel_d = '0; flush = 0; pipe_ack_i = 0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  // Reference model: lines as arrays, age order as a queue of line indices (oldest first).
  logic [20:0]  m_tag  [2];
  logic [15:0]  m_sel  [2];
  logic [255:0] m_data [2];
  int           age_q[$];
  bit           m_down, m_hit, m_evict, e_ack, e_busy;
  int           m_vic, m_idle, m_hidx, m_eidx;
  logic         e_stb;
  logic [20:0]  e_addr;
  logic [15:0]  e_sel;
  logic [255:0] e_do;
  localparam int MTO = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_sel[i] = '0; m_tag[i] = '0; m_data[i] = '0; end
    age_q.delete();
    m_down = 0; m_idle = 0; m_vic = 0;
    e_stb = 0; e_addr = '0; e_sel = '0; e_do = '0;
  endtask

  task automatic model_comb(input logic stb, input logic [24:0] a, input logic fl);
    bit all_e, any_e;
    m_hit = 0; m_hidx = 0; m_eidx = -1;
    for (int i = 0; i < 2; i++) begin
      if (m_sel[i] != 0 && m_tag[i] == a[24:4]) begin m_hit = 1; m_hidx = i; end
      if (m_sel[i] == 0 && m_eidx < 0) m_eidx = i;
    end
    any_e = (m_eidx >= 0);
    all_e = (m_sel[0] == 0) && (m_sel[1] == 0);
    m_evict = !m_down && ((stb && !m_hit && !any_e) || (fl && !all_e) ||
                          (MTO != 0 && m_idle == MTO && !all_e));
    e_ack  = !m_down && !fl && !m_evict && (m_hit || any_e);
    e_busy = m_down || (fl && !all_e);
  endtask

  task automatic model_edge(input logic stb, input logic [24:0] a, input logic [15:0] p,
                            input logic ak);
    bit all_e, acc, was_down;
    int idx, lane;
    all_e    = (m_sel[0] == 0) && (m_sel[1] == 0);
    acc      = stb && e_ack;
    was_down = m_down;
    if (!was_down && m_evict) begin
      m_vic = age_q[0];
      e_stb = 1; e_addr = m_tag[m_vic]; e_sel = m_sel[m_vic]; e_do = m_data[m_vic];
      m_down = 1;
    end else if (was_down && ak) begin
      m_sel[m_vic] = '0;
      age_q.delete(0);
      e_stb = 0; m_down = 0;
    end
    if (acc) begin
      idx = m_hit ? m_hidx : m_eidx;
      if (!m_hit) begin
        m_tag[idx] = a[24:4]; m_sel[idx] = '0; age_q.push_back(idx);
      end
      lane = 15 - int'(a[3:0]);
      m_sel[idx][lane] = 1'b1;
      m_data[idx][lane*16 +: 16] = p;
    end
    if ((!was_down && m_evict) || acc || all_e) m_idle = 0;
    else if (!was_down && m_idle < MTO) m_idle++;
  endtask

  typedef struct {
    logic        stb;
    logic [24:0] addr;
    logic        fl;
    logic        acki;
    logic        x_ack;
    logic        x_busy;
    logic        x_stb;
    logic [20:0] x_addr;
    logic [15:0] x_sel;
    logic [15:0] x_top;
  } vec_t;

  function automatic vec_t mk(input logic stb, input logic [24:0] a, input logic fl,
                              input logic ak, input logic xa, input logic xb, input logic xs,
                              input logic [20:0] xad, input logic [15:0] xsl, input logic [15:0] xt);
    vec_t v;
    v.stb = stb; v.addr = a; v.fl = fl; v.acki = ak; v.x_ack = xa; v.x_busy = xb;
    v.x_stb = xs; v.x_addr = xad; v.x_sel = xsl; v.x_top = xt;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    logic [24:0] a;
    logic [15:0] p;
    logic        stb, fl, ak;

    // Two interleaved lines, flush, then miss eviction; pixel i carries 0x1000+i.
    tbl[0]  = mk(1, 25'h40, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 25'h80, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 25'h41, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 25'h81, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 25'h0,  1, 0, 0, 1, 1, 21'h4, 16'hC000, 16'h1000);
    tbl[5]  = mk(0, 25'h0,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 25'h0,  1, 0, 0, 1, 1, 21'h8, 16'hC000, 16'h1001);
    tbl[7]  = mk(0, 25'h0,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 25'h0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 25'h40, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 25'h80, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 25'hC0, 0, 0, 0, 0, 1, 21'h4, 16'h8000, 16'h1009);
    tbl[12] = mk(1, 25'hC0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[13] = mk(1, 25'hC0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 25'h0,  1, 0, 0, 1, 1, 21'h8, 16'h8000, 16'h100A);
    tbl[15] = mk(0, 25'h0,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[16] = mk(0, 25'h0,  1, 0, 0, 1, 1, 21'hC, 16'h8000, 16'h100D);
    tbl[17] = mk(0, 25'h0,  1, 1, 0, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 25'h0,  1, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    chk("rst_stb", pipe_stb_o, 0);
    chk("rst_sel", burst_sel, 0);
    chk("rst_addr", burst_addr, 0);
    chk("rst_do", burst_do, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].stb, tbl[i].addr, 16'h1000 + 16'(i), tbl[i].fl, tbl[i].acki);
      chk($sformatf("tbl%0d_ack", i), c_ack, tbl[i].x_ack);
      chk($sformatf("tbl%0d_busy", i), c_busy, tbl[i].x_busy);
      chk($sformatf("tbl%0d_stb", i), pipe_stb_o, tbl[i].x_stb);
      if (tbl[i].x_stb) begin
        chk($sformatf("tbl%0d_addr", i), burst_addr, tbl[i].x_addr);
        chk($sformatf("tbl%0d_sel", i), burst_sel, tbl[i].x_sel);
        chk($sformatf("tbl%0d_top", i), burst_do[255:240], tbl[i].x_top);
      end
    end

    // Full line combine and flush.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 25'h40 + 25'(i), 16'h1000 + 16'(i), 0, 0);
      chk("full_ack", c_ack, 1);
    end
    step(0, 0, 0, 1, 0);
    chk("full_busy", c_busy, 1);
    chk("full_stb", pipe_stb_o, 1);
    chk("full_addr", burst_addr, 21'h4);
    chk("full_sel", burst_sel, 16'hFFFF);
    chk("full_top", burst_do[255:240], 16'h1000);
    chk("full_low", burst_do[15:0], 16'h100F);
    step(0, 0, 0, 1, 1);
    chk("full_stb_drop", pipe_stb_o, 0);
    step(0, 0, 0, 1, 0);
    chk("full_busy_end", c_busy, 0);

    // Backpressure on a miss eviction.
    do_reset();
    step(1, 25'h40, 16'hAAAA, 0, 0);
    step(1, 25'h80, 16'hBBBB, 0, 0);
    step(1, 25'hC0, 16'hCCCC, 0, 0);
    chk("bp_ack0", c_ack, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 25'hC0, 16'hCCCC, 0, 0);
      chk("bp_ack_hold", c_ack, 0);
      chk("bp_stb_hold", pipe_stb_o, 1);
      chk("bp_addr_hold", burst_addr, 21'h4);
      chk("bp_sel_hold", burst_sel, 16'h8000);
      chk("bp_top_hold", burst_do[255:240], 16'hAAAA);
    end
    step(1, 25'hC0, 16'hCCCC, 0, 1);
    chk("bp_ack_at_ack", c_ack, 0);
    chk("bp_stb_drop", pipe_stb_o, 0);
    step(1, 25'hC0, 16'hCCCC, 0, 0);
    chk("bp_ack_after", c_ack, 1);

    // Idle-timeout eviction, and a write restarting the count.
    do_reset();
    step(1, 25'h45, 16'h5555, 0, 0);
    chk("to_wr_ack", c_tack, 1);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("to_idle%0d_stb", i), t_stb, logic'(i == 9));
    end
    chk("to_sel", t_sel, 16'h0400);
    chk("to_addr", t_addr, 21'h4);
    chk("to_data", t_do[175:160], 16'h5555);
    step(0, 0, 0, 0, 1);
    chk("to_busy_down", c_tbusy, 1);
    chk("to_stb_drop", t_stb, 0);

    do_reset();
    step(1, 25'h45, 16'h5555, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    step(1, 25'h46, 16'h6666, 0, 0);
    chk("tor_wr_ack", c_tack, 1);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("tor_idle%0d_stb", i), t_stb, logic'(i == 9));
      if (i < 9) chk("tor_busy", c_tbusy, 0);
    end
    chk("tor_sel", t_sel, 16'h0600);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    step(1, 25'h40, 16'h1234, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("ar_stb_pre", pipe_stb_o, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_stb", pipe_stb_o, 0);
    chk("ar_sel", burst_sel, 0);
    chk("ar_busy", busy, 0);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("ar_flush_busy", c_busy, 0);
      chk("ar_flush_stb", pipe_stb_o, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      stb = ($urandom_range(0, 3) != 0);
      a   = {21'(4 * $urandom_range(1, 4)), 4'($urandom_range(0, 15))};
      p   = 16'($urandom);
      fl  = ($urandom_range(0, 19) == 0);
      ak  = ($urandom_range(0, 2) != 0);
      model_comb(stb, a, fl);
      step(stb, a, p, fl, ak);
      chk("rnd_ack", c_ack, e_ack);
      chk("rnd_busy", c_busy, e_busy);
      model_edge(stb, a, p, ak);
      chk("rnd_stb", pipe_stb_o, e_stb);
      if (e_stb) begin
        chk("rnd_addr", burst_addr, e_addr);
        chk("rnd_sel", burst_sel, e_sel);
        chk("rnd_do", burst_do, e_do);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tmu_burst_wc.md
Name: tmu_burst_wc

Overview:
Parametrised write-combining burst assembler for the TMU write-back path; successor to the single-line burst assembler.
- Collects destination pixels into nlines independent burst lines keyed by burst address.
- Emits each line as one FML-sized burst (data plus per-pixel select).
- Sits between the TMU pixel pipeline and the FML write master.
- Adds over the single-line version: multiple lines with oldest-first eviction, configurable pixel and burst widths, and an optional idle-timeout auto-flush.

Parameters:
- fml_depth, 26, FML byte-address width.
- pixel_width, 16, bits per pixel; 16 or 32.
- burst_width, 256, bits per burst; power of two, at least 2*pixel_width.
- nlines, 2, number of combining lines; 1, 2 or 4.
- timeout, 0, idle cycles before auto-eviction of the oldest non-empty line; 0 disables the feature.
- Derived: ppb = burst_width/pixel_width; ow = log2(ppb); aw = fml_depth - log2(pixel_width/8); bw = fml_depth - log2(burst_width/8).

Ports:
- sys_clk, in, 1, clock.
- sys_rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, drain all lines; input stalled while asserted.
- busy, out, 1, lines still draining (definition under Behaviour).
- pipe_stb_i, in, 1, upstream pixel valid.
- pipe_ack_o, out, 1, upstream pixel accepted; combinational.
- src_pixel_d, in, pixel_width, pixel data.
- dst_addr, in, aw, destination address in pixel units.
- pipe_stb_o, out, 1, burst valid; registered.
- pipe_ack_i, in, 1, burst accepted by FML master.
- burst_addr, out, bw, burst address in burst_width units; registered.
- burst_sel, out, ppb, per-pixel write enable; registered; the FML master expands it to byte enables.
- burst_do, out, burst_width, burst data; registered.

Behaviour:
- Reset: asynchronous and immediate, including mid-burst. pipe_stb_o, burst_addr, burst_sel, burst_do = 0. All line sel = 0, state = RUNNING, idle counter = 0. busy = 0.
- Line contents: tag [bw-1:0], sel [ppb-1:0], data [burst_width-1:0], age rank. A line is empty iff sel == 0.
- Lane mapping: offset off = dst_addr[ow-1:0].
  - Sets sel bit ppb-1-off.
  - Writes data slice [(ppb-off)*pixel_width-1 -: pixel_width].
  - Offset 0 is the MSB lane.
- hit: some non-empty line has tag == dst_addr[aw-1:ow]. At most one line can hit.
- States: RUNNING and DOWNSTREAM.
- pipe_ack_o = RUNNING & ~flush & ~evict_now & (hit | any_empty).
- On accept (pipe_stb_i & pipe_ack_o):
  - If hit, write into the hit line. Re-writing an already-set lane overwrites its data; sel is unchanged.
  - Otherwise allocate the lowest-index empty line: set tag, clear sel, then write. That line becomes youngest.
- evict_now, evaluated in RUNNING, is true if any of:
  - pipe_stb_i & ~hit & ~any_empty (miss with all lines full);
  - flush & ~all_empty;
  - timeout != 0 & idle counter == timeout & ~all_empty.
- RUNNING to DOWNSTREAM on evict_now:
  - Victim = oldest non-empty line.
  - Next edge loads burst_addr, burst_sel, burst_do from the victim and sets pipe_stb_o = 1.
- DOWNSTREAM:
  - Outputs held stable; no pixel accepted.
  - On pipe_ack_i, the victim sel is cleared at the same edge, pipe_stb_o drops, state returns to RUNNING.
  - Minimum burst occupancy is one cycle (ack in the first DOWNSTREAM cycle).
- Miss stall: the stalled pixel is accepted in the first RUNNING cycle after eviction, into the freed line. No pixel is ever dropped or reordered within a lane.
- Idle counter:
  - Increments in RUNNING when no accept and ~all_empty; saturates at timeout.
  - Clears on accept, on entering DOWNSTREAM, and when all lines are empty.
- busy = (state == DOWNSTREAM) | (flush & ~all_empty). Combinational.
- Flush completion: busy low with flush high means every line is empty.
- nlines = 1: pure single-line combining with stall-on-miss.
- pipe_ack_i while pipe_stb_o = 0 is ignored.

Decomposition:
- Shared package tmu_pkg: clog2 function, RUNNING/DOWNSTREAM encodings, and the derived-width macros (ppb, ow, bw).
- Sub-module tmu_burst_line: one combining line, holding tag, sel and data registers, with write/clear strobes and lane decode. Instantiated nlines times.
- Top level holds age ranks, hit and victim selection, FSM, idle counter and output registers.

Test Plan:
- Defaults used unless stated: pixel_width 16, burst_width 256, nlines 2, timeout 0.
- Combine and flush: write 16 pixels to dst_addr 0x40..0x4F with data 0x1000+i, then pulse flush -> one burst with burst_addr 0x4, burst_sel 0xFFFF, burst_do[255:240] = 0x1000, burst_do[15:0] = 0x100F; busy falls after ack.
- Two lines: alternate pixels to 0x40, 0x80, 0x41, 0x81 -> all acked back-to-back and no burst before flush; flush gives burst 0x4 (sel 0xC000) then burst 0x8 (sel 0xC000).
- Eviction: lines hold tags 0x4 (older) and 0x8, then write 0xC0 -> pipe_ack_o low; burst 0x4 emitted; after pipe_ack_i, pixel 0xC0 is acked the next cycle.
- Backpressure: hold pipe_ack_i low for 5 cycles -> pipe_stb_o and burst_* stable and pipe_ack_o low throughout; sel of the victim cleared only at the ack edge.
- Timeout = 8: write one pixel to 0x45 then idle -> pipe_stb_o rises with sel 0x0400 at the 9th idle cycle edge; a write at idle cycle 7 restarts the count.
- Reset mid-burst: assert sys_rst_n low while pipe_stb_o = 1, asynchronous to the clock -> pipe_stb_o, burst_sel and busy go 0 immediately; after release a flush produces no burst.
